// File: rtl/pc_stack_ctrl.sv
// PIC16C5x program counter, Q-phase sequencer and hardware call stack.
// Optional overflow/underflow flags are built when PCSTK_OVF_FLAG_EN is defined.
module pc_stack_ctrl #(
  parameter int                  PC_WIDTH     = 11,
  parameter int                  STACK_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pa,
  input  logic                op_goto,
  input  logic                op_call,
  input  logic                op_ret,
  input  logic                op_pclwr,
  input  logic                skip_req,
  input  logic [8:0]          target_k,
  input  logic [7:0]          pcl_data,
  output logic [1:0]          q_phase,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                fetch_en,
  output logic                flush
`ifdef PCSTK_OVF_FLAG_EN
  ,
  output logic                stk_ovf,
  output logic                stk_unf
`endif
);

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

  phase_t              phase, phase_next;
  logic [PC_WIDTH-1:0] stk [STACK_DEPTH];
  logic                take, do_call, do_ret, skip_ok;
  logic [10:0]         tgt_full;
  logic [PC_WIDTH-1:0] tgt;

  assign q_phase  = phase;
  assign fetch_en = (phase == Q4);

  always_comb begin
    phase_next = phase;
    case (phase)
      Q1: phase_next = Q2;
      Q2: phase_next = Q3;
      Q3: phase_next = Q4;
      Q4: phase_next = Q1;
      default: phase_next = Q1;
    endcase
  end

  // Q4 decode: requests count only for a non-flushed instruction, RETLW first.
  always_comb begin
    take     = 1'b0;
    do_call  = 1'b0;
    do_ret   = 1'b0;
    skip_ok  = 1'b0;
    tgt_full = '0;
    if (phase == Q4 && !flush) begin
      skip_ok = skip_req;
      if (op_ret) begin
        take   = 1'b1;
        do_ret = 1'b1;
      end else if (op_call) begin
        take     = 1'b1;
        do_call  = 1'b1;
        tgt_full = {pa, 1'b0, target_k[7:0]};
      end else if (op_goto) begin
        take     = 1'b1;
        tgt_full = {pa, target_k};
      end else if (op_pclwr) begin
        take     = 1'b1;
        tgt_full = {pa, 1'b0, pcl_data};
      end
    end
    tgt = do_ret ? stk[0] : tgt_full[PC_WIDTH-1:0];
  end

  // The Q4->Q1 edge commits the instruction; pc_out already holds the return address.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= Q3;
      pc_out <= RESET_VECTOR;
      flush  <= 1'b1;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      phase <= phase_next;
      if (phase == Q4) begin
        pc_out <= take ? tgt : pc_out + PC_WIDTH'(1);
        flush  <= take | skip_ok;
      end
      if (do_call) begin
        stk[0] <= pc_out;
        for (int i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
      end else if (do_ret) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
      end
    end
  end

`ifdef PCSTK_OVF_FLAG_EN
  localparam int             DW   = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DMAX = DW'(STACK_DEPTH);

  logic [DW-1:0] depth;

  // Depth saturates at both ends; the sticky flags record any lost or bogus entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (do_call) begin
      if (depth == DMAX) stk_ovf <= 1'b1;
      else               depth   <= depth + DW'(1);
    end else if (do_ret) begin
      if (depth == '0) stk_unf <= 1'b1;
      else             depth   <= depth - DW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Bench for pc_stack_ctrl: per-instruction-cycle vector table with a scoreboard queue,
// plus reset corner sequences. Flag checks are compiled in with PCSTK_OVF_FLAG_EN.
module tb_pc_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pa = '0;
  logic        op_goto = 1'b0, op_call = 1'b0, op_ret = 1'b0, op_pclwr = 1'b0, skip_req = 1'b0;
  logic [8:0]  target_k = '0;
  logic [7:0]  pcl_data = '0;
  logic [1:0]  q_phase;
  logic [10:0] pc_out;
  logic        fetch_en, flush;
  logic        stk_ovf, stk_unf;

  pc_stack_ctrl dut (
    .clk(clk), .rst(rst), .pa(pa),
    .op_goto(op_goto), .op_call(op_call), .op_ret(op_ret), .op_pclwr(op_pclwr),
    .skip_req(skip_req), .target_k(target_k), .pcl_data(pcl_data),
    .q_phase(q_phase), .pc_out(pc_out), .fetch_en(fetch_en), .flush(flush)
`ifdef PCSTK_OVF_FLAG_EN
    , .stk_ovf(stk_ovf), .stk_unf(stk_unf)
`endif
  );

`ifndef PCSTK_OVF_FLAG_EN
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ops;   // {ret, call, goto, pclwr, skip}
    logic [1:0]  pa;
    logic [8:0]  k;
    logic [7:0]  pcl;
    logic [10:0] epc;
    logic        efl, eovf, eunf;
  } vec_t;

  typedef struct {
    logic [10:0] pc;
    logic        fl, ovf, unf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] ops, input logic [1:0] p, input logic [8:0] k,
                     input logic [7:0] pcl, input logic [10:0] epc, input logic efl,
                     input logic eovf, input logic eunf);
    vec_t v;
    v.ops = ops; v.pa = p; v.k = k; v.pcl = pcl;
    v.epc = epc; v.efl = efl; v.eovf = eovf; v.eunf = eunf;
    vecs.push_back(v);
  endtask

  task automatic wait_q4();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (q_phase == 2'd3) break;
    end
    check("q4_reached", q_phase, 32'd3);
    check("fetch_en_q4", fetch_en, 32'd1);
  endtask

  // One instruction cycle: requests presented in Q4, result observed in the following Q1.
  task automatic exec(input vec_t v);
    exp_t e;
    wait_q4();
    {op_ret, op_call, op_goto, op_pclwr, skip_req} = v.ops;
    pa = v.pa; target_k = v.k; pcl_data = v.pcl;
    e.pc = v.epc; e.fl = v.efl; e.ovf = v.eovf; e.unf = v.eunf;
    sb.push_back(e);
    @(negedge clk);
    {op_ret, op_call, op_goto, op_pclwr, skip_req} = '0;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("pc_q1", pc_out, e.pc);
      check("flush_q1", flush, e.fl);
      check("phase_q1", q_phase, 32'd0);
      check("fetch_en_q1", fetch_en, 32'd0);
`ifdef PCSTK_OVF_FLAG_EN
      check("stk_ovf", stk_ovf, e.ovf);
      check("stk_unf", stk_unf, e.unf);
`endif
    end
  endtask

  task automatic check_reset_state();
    check("rst_pc", pc_out, 32'h7FF);
    check("rst_phase", q_phase, 32'd2);
    check("rst_flush", flush, 32'd1);
`ifdef PCSTK_OVF_FLAG_EN
    check("rst_ovf", stk_ovf, 32'd0);
    check("rst_unf", stk_unf, 32'd0);
`endif
  endtask

  initial begin
    vec_t v;
    // ops: {ret, call, goto, pclwr, skip}
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0); // first Q4 after reset
    add(5'b00100, 2'd1, 9'h0A5, 8'h00, 11'h2A5, 1'b1, 1'b0, 1'b0); // goto page 1
    add(5'b00100, 2'd0, 9'h000, 8'h00, 11'h2A6, 1'b0, 1'b0, 1'b0); // flushed goto ignored
    add(5'b00100, 2'd0, 9'h010, 8'h00, 11'h010, 1'b1, 1'b0, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h011, 1'b0, 1'b0, 1'b0);
    add(5'b01000, 2'd0, 9'h1C3, 8'h00, 11'h0C3, 1'b1, 1'b0, 1'b0); // call from 011
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h0C4, 1'b0, 1'b0, 1'b0);
    add(5'b10000, 2'd0, 9'h000, 8'h00, 11'h011, 1'b1, 1'b0, 1'b0); // retlw
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h012, 1'b0, 1'b0, 1'b0);
    add(5'b00001, 2'd0, 9'h000, 8'h00, 11'h013, 1'b1, 1'b0, 1'b0); // skip
    add(5'b00101, 2'd3, 9'h1FF, 8'h00, 11'h014, 1'b0, 1'b0, 1'b0); // flushed goto+skip ignored
    add(5'b00101, 2'd0, 9'h020, 8'h00, 11'h020, 1'b1, 1'b0, 1'b0); // goto+skip: one flush
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h021, 1'b0, 1'b0, 1'b0);
    add(5'b00010, 2'd2, 9'h000, 8'h55, 11'h455, 1'b1, 1'b0, 1'b0); // PCL write
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h456, 1'b0, 1'b0, 1'b0);
    add(5'b01110, 2'd0, 9'h1C3, 8'hFF, 11'h0C3, 1'b1, 1'b0, 1'b0); // call beats goto/pclwr
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h0C4, 1'b0, 1'b0, 1'b0);
    add(5'b11000, 2'd0, 9'h1C3, 8'h00, 11'h456, 1'b1, 1'b0, 1'b0); // ret beats call
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h457, 1'b0, 1'b0, 1'b0);
    add(5'b00110, 2'd1, 9'h033, 8'h77, 11'h233, 1'b1, 1'b0, 1'b0); // goto beats pclwr
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h234, 1'b0, 1'b0, 1'b0);
    add(5'b00100, 2'd3, 9'h1FF, 8'h00, 11'h7FF, 1'b1, 1'b0, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0); // PC wraps
    add(5'b00100, 2'd0, 9'h010, 8'h00, 11'h010, 1'b1, 1'b0, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h011, 1'b0, 1'b0, 1'b0);
    add(5'b01000, 2'd0, 9'h1FF, 8'h00, 11'h0FF, 1'b1, 1'b0, 1'b0); // call drops k[8]
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h100, 1'b0, 1'b0, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h101, 1'b0, 1'b0, 1'b0);
    add(5'b01000, 2'd1, 9'h000, 8'h00, 11'h200, 1'b1, 1'b0, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h201, 1'b0, 1'b0, 1'b0);
    add(5'b01000, 2'd2, 9'h010, 8'h00, 11'h410, 1'b1, 1'b1, 1'b0); // third call overflows
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h411, 1'b0, 1'b1, 1'b0);
    add(5'b10000, 2'd0, 9'h000, 8'h00, 11'h201, 1'b1, 1'b1, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h202, 1'b0, 1'b1, 1'b0);
    add(5'b10000, 2'd0, 9'h000, 8'h00, 11'h101, 1'b1, 1'b1, 1'b0);
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h102, 1'b0, 1'b1, 1'b0);
    add(5'b10000, 2'd0, 9'h000, 8'h00, 11'h101, 1'b1, 1'b1, 1'b1); // bottom entry duplicated
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h102, 1'b0, 1'b1, 1'b1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) exec(vecs[i]);

    // Reset at the edge that would apply a decided GOTO: the target must never appear.
    wait_q4();
    op_goto = 1'b1; pa = 2'd1; target_k = 9'h0A5; rst = 1'b1;
    @(negedge clk);
    op_goto = 1'b0; rst = 1'b0;
    check_reset_state();
    add(5'b00000, 2'd0, 9'h000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0);
    exec(vecs[vecs.size()-1]);
    // Stack was cleared: RETLW on the empty stack returns 0.
    add(5'b10000, 2'd0, 9'h000, 8'h00, 11'h000, 1'b1, 1'b0, 1'b1);
    exec(vecs[vecs.size()-1]);

    // Reset landing mid-cycle (Q2).
    @(negedge clk);
    check("pre_midrst_phase", q_phase, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    v.ops = '0; v.pa = '0; v.k = '0; v.pcl = '0;
    v.epc = 11'h000; v.efl = 1'b0; v.eovf = 1'b0; v.eunf = 1'b0;
    exec(v);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
